// File: rtl/eth_header_rx.sv
// Ethernet II receive header parser: captures destination/source MAC and EtherType,
// filters on destination address and pulses ARP / IPv4 / drop once per complete header.
module eth_header_rx #(
    parameter bit PROMISC = 1'b0
) (
    input  logic        aclk,
    input  logic        areset,
    input  logic [47:0] local_mac,
    input  logic [7:0]  data_in,
    input  logic        data_valid,
    input  logic        rx_abort,
    input  logic        preamble_sfd_rx_done,
    output logic [47:0] mac_d_addr,
    output logic [47:0] mac_s_addr,
    output logic [15:0] eth_type,
    output logic        eth_header_arp_rx_done,
    output logic        eth_header_ip_rx_done,
    output logic        eth_header_rx_drop
);

    typedef enum logic [1:0] {
        WAIT_START         = 2'd0,
        MAC_DESTINATION_RX = 2'd1,
        MAC_SOURCE_RX      = 2'd2,
        ETH_TYPE_RX        = 2'd3
    } state_t;

    state_t      state_q;
    logic [2:0]  count_q;
    logic [47:0] dst_q;
    logic [47:0] src_q;
    logic [15:0] type_q;
    logic [47:0] mac_d_q;
    logic [47:0] mac_s_q;
    logic [15:0] eth_type_q;
    logic        arp_q;
    logic        ip_q;
    logic        drop_q;

    logic [15:0] type_d;
    logic        addr_ok_d;

    // EtherType including the byte on data_in, and the destination filter verdict
    always_comb begin
        type_d    = {type_q[7:0], data_in};
        addr_ok_d = 1'b0;
        if (PROMISC || (dst_q == local_mac) || (dst_q == 48'hFFFF_FFFF_FFFF)) begin
            addr_ok_d = 1'b1;
        end else begin
            addr_ok_d = 1'b0;
        end
    end

    // Header FSM with shadow capture and registered result fields/pulses
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q    <= WAIT_START;
            count_q    <= 3'd0;
            dst_q      <= 48'd0;
            src_q      <= 48'd0;
            type_q     <= 16'd0;
            mac_d_q    <= 48'd0;
            mac_s_q    <= 48'd0;
            eth_type_q <= 16'd0;
            arp_q      <= 1'b0;
            ip_q       <= 1'b0;
            drop_q     <= 1'b0;
        end else begin
            arp_q  <= 1'b0;
            ip_q   <= 1'b0;
            drop_q <= 1'b0;
            case (state_q)
                WAIT_START: begin
                    // a data_valid alongside the SFD pulse is the SFD byte itself
                    if (preamble_sfd_rx_done) begin
                        state_q <= MAC_DESTINATION_RX;
                        count_q <= 3'd0;
                    end
                end
                default: begin
                    if (rx_abort) begin
                        state_q <= WAIT_START;
                        count_q <= 3'd0;
                    end else if (preamble_sfd_rx_done) begin
                        state_q <= MAC_DESTINATION_RX;
                        count_q <= 3'd0;
                    end else if (data_valid) begin
                        case (state_q)
                            MAC_DESTINATION_RX: begin
                                dst_q <= {dst_q[39:0], data_in};
                                if (count_q == 3'd5) begin
                                    state_q <= MAC_SOURCE_RX;
                                    count_q <= 3'd0;
                                end else begin
                                    count_q <= count_q + 3'd1;
                                end
                            end
                            MAC_SOURCE_RX: begin
                                src_q <= {src_q[39:0], data_in};
                                if (count_q == 3'd5) begin
                                    state_q <= ETH_TYPE_RX;
                                    count_q <= 3'd0;
                                end else begin
                                    count_q <= count_q + 3'd1;
                                end
                            end
                            ETH_TYPE_RX: begin
                                type_q <= type_d;
                                if (count_q == 3'd1) begin
                                    state_q    <= WAIT_START;
                                    count_q    <= 3'd0;
                                    mac_d_q    <= dst_q;
                                    mac_s_q    <= src_q;
                                    eth_type_q <= type_d;
                                    if (addr_ok_d && (type_d == 16'h0806)) begin
                                        arp_q <= 1'b1;
                                    end else if (addr_ok_d && (type_d == 16'h0800)) begin
                                        ip_q <= 1'b1;
                                    end else begin
                                        drop_q <= 1'b1;
                                    end
                                end else begin
                                    count_q <= count_q + 3'd1;
                                end
                            end
                            default: begin
                                state_q <= WAIT_START;
                                count_q <= 3'd0;
                            end
                        endcase
                    end
                end
            endcase
        end
    end

    assign mac_d_addr             = mac_d_q;
    assign mac_s_addr             = mac_s_q;
    assign eth_type               = eth_type_q;
    assign eth_header_arp_rx_done = arp_q;
    assign eth_header_ip_rx_done  = ip_q;
    assign eth_header_rx_drop     = drop_q;

endmodule

// File: tb/tb_eth_header_rx.sv
// Self-checking bench for eth_header_rx: table-driven frames, hand-written corner sequences
// and randomized traffic, all compared every cycle against a byte-queue reference model.
module tb_eth_header_rx;

    logic        aclk = 1'b0;
    logic        areset = 1'b1;
    logic [47:0] local_mac = 48'h0200_0000_0001;
    logic [7:0]  din = 8'd0;
    logic        dv = 1'b0;
    logic        abort = 1'b0;
    logic        sfd = 1'b0;

    logic [47:0] d_addr [2];
    logic [47:0] s_addr [2];
    logic [15:0] etype [2];
    logic        arp [2];
    logic        ip [2];
    logic        drop [2];

    eth_header_rx #(.PROMISC(1'b0)) u_dut0 (
        .aclk(aclk), .areset(areset), .local_mac(local_mac), .data_in(din),
        .data_valid(dv), .rx_abort(abort), .preamble_sfd_rx_done(sfd),
        .mac_d_addr(d_addr[0]), .mac_s_addr(s_addr[0]), .eth_type(etype[0]),
        .eth_header_arp_rx_done(arp[0]), .eth_header_ip_rx_done(ip[0]),
        .eth_header_rx_drop(drop[0]));

    eth_header_rx #(.PROMISC(1'b1)) u_dut1 (
        .aclk(aclk), .areset(areset), .local_mac(local_mac), .data_in(din),
        .data_valid(dv), .rx_abort(abort), .preamble_sfd_rx_done(sfd),
        .mac_d_addr(d_addr[1]), .mac_s_addr(s_addr[1]), .eth_type(etype[1]),
        .eth_header_arp_rx_done(arp[1]), .eth_header_ip_rx_done(ip[1]),
        .eth_header_rx_drop(drop[1]));

    always #5 aclk = ~aclk;

    int n_tests = 0;
    int n_fail  = 0;
    int step_no = 0;
    int pulse_cnt [2];
    int last_kind [2];
    int last_pulse_step = 0;

    // reference model: bytes since SFD kept in a queue, header decoded once 14 are present
    bit          m_in = 1'b0;
    logic [7:0]  m_q [$];
    logic [47:0] m_dst = 48'd0;
    logic [47:0] m_src = 48'd0;
    logic [15:0] m_type = 16'd0;
    bit          m_arp [2];
    bit          m_ip [2];
    bit          m_drop [2];

    typedef struct {
        logic [47:0] dst;
        logic [47:0] src;
        logic [15:0] typ;
        int          gap;
        int          kind0;
        int          kind1;
    } frame_t;

    frame_t frames [4];

    task automatic chk(input string nm, input logic [47:0] act, input logic [47:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (step %0d)", nm, act, exp, step_no);
        end
    endtask

    task automatic model_clear();
        m_in = 1'b0;
        m_q.delete();
        m_dst = 48'd0; m_src = 48'd0; m_type = 16'd0;
        for (int p = 0; p < 2; p++) begin
            m_arp[p] = 1'b0; m_ip[p] = 1'b0; m_drop[p] = 1'b0;
        end
    endtask

    task automatic model_edge();
        logic [47:0] dst;
        logic [47:0] src;
        logic [15:0] typ;
        bit          ok;
        if (areset) begin
            model_clear();
            return;
        end
        for (int p = 0; p < 2; p++) begin
            m_arp[p] = 1'b0; m_ip[p] = 1'b0; m_drop[p] = 1'b0;
        end
        if (!m_in) begin
            if (sfd) begin m_in = 1'b1; m_q.delete(); end
        end else if (abort) begin
            m_in = 1'b0;
        end else if (sfd) begin
            m_q.delete();
        end else if (dv) begin
            m_q.push_back(din);
            if (m_q.size() == 14) begin
                dst = 48'd0; src = 48'd0;
                for (int i = 0; i < 6; i++) begin
                    dst = dst * 48'd256 + {40'd0, m_q[i]};
                    src = src * 48'd256 + {40'd0, m_q[6 + i]};
                end
                typ = {m_q[12], m_q[13]};
                m_dst = dst; m_src = src; m_type = typ;
                for (int p = 0; p < 2; p++) begin
                    ok = (p == 1) || (dst == local_mac) || (dst == 48'hFFFF_FFFF_FFFF);
                    if (ok && typ == 16'h0806) m_arp[p] = 1'b1;
                    else if (ok && typ == 16'h0800) m_ip[p] = 1'b1;
                    else m_drop[p] = 1'b1;
                end
                m_in = 1'b0;
            end
        end
    endtask

    task automatic compare_all();
        for (int p = 0; p < 2; p++) begin
            chk($sformatf("mac_d_addr[%0d]", p), d_addr[p], m_dst);
            chk($sformatf("mac_s_addr[%0d]", p), s_addr[p], m_src);
            chk($sformatf("eth_type[%0d]", p), {32'd0, etype[p]}, {32'd0, m_type});
            chk($sformatf("arp_done[%0d]", p), {47'd0, arp[p]}, {47'd0, m_arp[p]});
            chk($sformatf("ip_done[%0d]", p), {47'd0, ip[p]}, {47'd0, m_ip[p]});
            chk($sformatf("rx_drop[%0d]", p), {47'd0, drop[p]}, {47'd0, m_drop[p]});
        end
    endtask

    task automatic step();
        @(posedge aclk);
        model_edge();
        step_no++;
        #1;
        compare_all();
        for (int p = 0; p < 2; p++) begin
            if (arp[p] || ip[p] || drop[p]) begin
                pulse_cnt[p]++;
                last_kind[p] = arp[p] ? 0 : (ip[p] ? 1 : 2);
                if (p == 0) last_pulse_step = step_no;
            end
        end
    endtask

    task automatic idle(input int n);
        dv = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic send_byte(input logic [7:0] b);
        din = b; dv = 1'b1;
        step();
        dv = 1'b0;
    endtask

    task automatic sfd_pulse();
        sfd = 1'b1;
        step();
        sfd = 1'b0;
    endtask

    task automatic build(input logic [47:0] dst, input logic [47:0] src,
                         input logic [15:0] typ, output logic [7:0] hdr [14]);
        for (int i = 0; i < 6; i++) begin
            hdr[i]     = dst[8*(5-i) +: 8];
            hdr[6 + i] = src[8*(5-i) +: 8];
        end
        hdr[12] = typ[15:8];
        hdr[13] = typ[7:0];
    endtask

    task automatic clear_pulses();
        pulse_cnt[0] = 0; pulse_cnt[1] = 0;
        last_kind[0] = -1; last_kind[1] = -1;
    endtask

    initial begin
        logic [7:0]  hdr [14];
        logic [63:0] r64;
        logic [47:0] rdst;
        logic [15:0] rtyp;
        int          sfd_step;
        frame_t      f;

        frames[0] = '{48'h0200_0000_0001, 48'h1122_3344_5566, 16'h0806, 0, 0, 0};
        frames[1] = '{48'hFFFF_FFFF_FFFF, 48'hA0B0_C0D0_E0F0, 16'h0800, 3, 1, 1};
        frames[2] = '{48'h0200_0000_0002, 48'h0A0B_0C0D_0E0F, 16'h0800, 0, 2, 1};
        frames[3] = '{48'h0200_0000_0001, 48'h1234_5678_9ABC, 16'h86DD, 1, 2, 2};

        model_clear();
        clear_pulses();
        #2;
        step(); step();
        areset = 1'b0;
        idle(2);

        for (int k = 0; k < 4; k++) begin
            f = frames[k];
            clear_pulses();
            build(f.dst, f.src, f.typ, hdr);
            sfd_pulse();
            sfd_step = step_no;
            for (int i = 0; i < 14; i++) begin
                send_byte(hdr[i]);
                if (i == 6 && f.gap > 0) idle(f.gap);
            end
            idle(2);
            chk($sformatf("f%0d_pulses0", k), 48'(pulse_cnt[0]), 48'd1);
            chk($sformatf("f%0d_pulses1", k), 48'(pulse_cnt[1]), 48'd1);
            chk($sformatf("f%0d_kind0", k), 48'(last_kind[0]), 48'(f.kind0));
            chk($sformatf("f%0d_kind1", k), 48'(last_kind[1]), 48'(f.kind1));
            chk($sformatf("f%0d_latency", k), 48'(last_pulse_step - sfd_step), 48'(14 + f.gap));
            chk($sformatf("f%0d_dst", k), d_addr[0], f.dst);
            chk($sformatf("f%0d_src", k), s_addr[0], f.src);
            chk($sformatf("f%0d_type", k), {32'd0, etype[0]}, {32'd0, f.typ});
        end

        // abort at byte 9, then a good frame
        clear_pulses();
        build(48'h0200_0000_0001, 48'hDEAD_BEEF_0001, 16'h0800, hdr);
        sfd_pulse();
        for (int i = 0; i < 8; i++) send_byte(hdr[i]);
        abort = 1'b1;
        send_byte(hdr[8]);
        abort = 1'b0;
        for (int i = 9; i < 14; i++) send_byte(hdr[i]);
        idle(2);
        chk("abort_no_pulse", 48'(pulse_cnt[0] + pulse_cnt[1]), 48'd0);
        chk("abort_hold_type", {32'd0, etype[0]}, 48'h86DD);
        chk("abort_hold_src", s_addr[0], 48'h1234_5678_9ABC);
        clear_pulses();
        sfd_pulse();
        for (int i = 0; i < 14; i++) send_byte(hdr[i]);
        idle(1);
        chk("after_abort_kind", 48'(last_kind[0]), 48'd1);
        chk("after_abort_src", s_addr[0], 48'hDEAD_BEEF_0001);

        // resync at byte 4, then a full header
        clear_pulses();
        build(48'hFFFF_FFFF_FFFF, 48'h0000_0000_0077, 16'h0806, hdr);
        sfd_pulse();
        for (int i = 0; i < 3; i++) send_byte(8'h55);
        sfd = 1'b1;
        send_byte(8'h55);
        sfd = 1'b0;
        for (int i = 0; i < 14; i++) send_byte(hdr[i]);
        idle(3);
        chk("resync_pulses", 48'(pulse_cnt[0]), 48'd1);
        chk("resync_kind", 48'(last_kind[0]), 48'd0);
        chk("resync_src", s_addr[0], 48'h0000_0000_0077);

        // resync together with abort: abort wins, trailing bytes are ignored
        clear_pulses();
        sfd_pulse();
        for (int i = 0; i < 3; i++) send_byte(hdr[i]);
        sfd = 1'b1; abort = 1'b1;
        step();
        sfd = 1'b0; abort = 1'b0;
        for (int i = 0; i < 14; i++) send_byte(hdr[i]);
        idle(3);
        chk("sfd_abort_no_pulse", 48'(pulse_cnt[0] + pulse_cnt[1]), 48'd0);

        // asynchronous reset at byte 12
        clear_pulses();
        sfd_pulse();
        for (int i = 0; i < 11; i++) send_byte(hdr[i]);
        din = hdr[11]; dv = 1'b1;
        #3;
        areset = 1'b1;
        #1;
        chk("rst_async_dst", d_addr[0], 48'd0);
        chk("rst_async_src", s_addr[0], 48'd0);
        chk("rst_async_type", {32'd0, etype[0]}, 48'd0);
        chk("rst_async_type_p", {32'd0, etype[1]}, 48'd0);
        model_clear();
        step();
        areset = 1'b0;
        dv = 1'b0;
        for (int i = 12; i < 14; i++) send_byte(hdr[i]);
        idle(3);
        chk("rst_no_pulse", 48'(pulse_cnt[0] + pulse_cnt[1]), 48'd0);

        // randomized traffic against the model
        for (int k = 0; k < 60; k++) begin
            r64 = {$urandom(), $urandom()};
            if ($urandom_range(0, 3) == 0) local_mac = r64[47:0];
            case ($urandom_range(0, 3))
                0: rdst = local_mac;
                1: rdst = 48'hFFFF_FFFF_FFFF;
                2: rdst = local_mac ^ (48'd1 << $urandom_range(0, 47));
                default: begin r64 = {$urandom(), $urandom()}; rdst = r64[47:0]; end
            endcase
            case ($urandom_range(0, 3))
                0: rtyp = 16'h0806;
                1: rtyp = 16'h0800;
                2: rtyp = 16'h86DD;
                default: rtyp = 16'($urandom());
            endcase
            r64 = {$urandom(), $urandom()};
            build(rdst, r64[47:0], rtyp, hdr);
            sfd_pulse();
            for (int i = 0; i < 14; i++) begin
                if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
                case ($urandom_range(0, 39))
                    0: abort = 1'b1;
                    1: sfd = 1'b1;
                    default: ;
                endcase
                send_byte(hdr[i]);
                abort = 1'b0; sfd = 1'b0;
            end
            idle($urandom_range(0, 2));
        end
        idle(3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
